// File: rtl/icb_dem_tap_responder.sv
// Delay-tap responder: LOAD/step the tap, settle for SETTLE_CNT cycles, then flag taps outside the eye.
// Build option: define ICB_DEM_JITTER_EN to dither flag setting near the eye edges with a 16-bit LFSR.
module icb_dem_tap_responder #(
   parameter int TAP_CNT_WIDTH = 8,
   parameter int EYE_LO        = 64,
   parameter int EYE_HI        = 160,
   parameter int SETTLE_CNT    = 4
) (
   input  logic                     SCLK,
   input  logic                     RESET,
   input  logic                     ICB_CLK_ALGN_LOAD,
   input  logic [TAP_CNT_WIDTH-1:0] ICB_CLK_ALGN_TAPDLY,
   input  logic                     ICB_CLK_ALGN_MOV,
   input  logic                     ICB_CLK_ALGN_DIR,
   input  logic                     ICB_CLK_ALGN_CLR_FLGS,
   output logic                     IOD_EARLY,
   output logic                     IOD_LATE,
   output logic                     IOD_OOR,
   output logic [TAP_CNT_WIDTH-1:0] TAP_VALUE,
   output logic                     BUSY
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_EVAL   = 2'd2
   } state_t;

   localparam logic [TAP_CNT_WIDTH-1:0] TAP_MAX  = '1;
   localparam logic [TAP_CNT_WIDTH-1:0] TAP_ONE  = TAP_CNT_WIDTH'(1);
   localparam logic [3:0]               CNT_INIT = 4'(SETTLE_CNT - 1);

   state_t                     r_state, w_state_nxt;
   logic [TAP_CNT_WIDTH-1:0]   r_tap, w_tap_nxt;
   logic [3:0]                 r_cnt, w_cnt_nxt;
   logic                       r_early, r_late, r_oor;
   logic                       w_set_early, w_set_late, w_set_oor;
   logic                       w_below, w_above, w_gate_lo, w_gate_hi;
   logic signed [31:0]         w_tap_i;

   assign w_tap_i = signed'(32'(r_tap));
   assign w_below = w_tap_i < EYE_LO;
   assign w_above = w_tap_i > EYE_HI;

`ifdef ICB_DEM_JITTER_EN
   logic [15:0] r_lfsr;

   always_ff @(posedge SCLK) begin
      if (RESET) r_lfsr <= 16'hACE1;
      else       r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
   end

   // Within three taps outside the eye the flag only lands when the LFSR allows it.
   assign w_gate_lo = (w_tap_i < EYE_LO - 3) | r_lfsr[0];
   assign w_gate_hi = (w_tap_i > EYE_HI + 3) | r_lfsr[0];
`else
   assign w_gate_lo = 1'b1;
   assign w_gate_hi = 1'b1;
`endif

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can infer a latch.
      w_state_nxt = r_state;
      w_tap_nxt   = r_tap;
      w_cnt_nxt   = r_cnt;
      w_set_early = 1'b0;
      w_set_late  = 1'b0;
      w_set_oor   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (ICB_CLK_ALGN_MOV) begin
               w_state_nxt = ST_SETTLE;
               w_cnt_nxt   = CNT_INIT;
               if (ICB_CLK_ALGN_DIR) begin
                  if (r_tap == TAP_MAX) w_set_oor = 1'b1;
                  else                  w_tap_nxt = r_tap + TAP_ONE;
               end else begin
                  if (r_tap == '0)      w_set_oor = 1'b1;
                  else                  w_tap_nxt = r_tap - TAP_ONE;
               end
            end
         end
         ST_SETTLE: begin
            if (r_cnt == '0) w_state_nxt = ST_EVAL;
            else             w_cnt_nxt   = r_cnt - 4'd1;
         end
         ST_EVAL: begin
            w_state_nxt = ST_IDLE;
            w_set_early = w_below & w_gate_lo;
            w_set_late  = w_above & w_gate_hi;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
      // LOAD is honoured in every state, drops a coincident MOV and restarts settling.
      if (ICB_CLK_ALGN_LOAD) begin
         w_state_nxt = ST_SETTLE;
         w_tap_nxt   = ICB_CLK_ALGN_TAPDLY;
         w_cnt_nxt   = CNT_INIT;
         w_set_oor   = 1'b0;
      end
   end

   always_ff @(posedge SCLK) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (RESET) begin
         r_state <= ST_IDLE;
         r_tap   <= '0;
         r_cnt   <= '0;
         r_early <= 1'b0;
         r_late  <= 1'b0;
         r_oor   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_tap   <= w_tap_nxt;
         r_cnt   <= w_cnt_nxt;
         r_early <= w_set_early | (r_early & ~ICB_CLK_ALGN_CLR_FLGS);
         r_late  <= w_set_late  | (r_late  & ~ICB_CLK_ALGN_CLR_FLGS);
         r_oor   <= w_set_oor   | (r_oor   & ~ICB_CLK_ALGN_CLR_FLGS);
      end
   end

   assign TAP_VALUE = r_tap;
   assign BUSY      = (r_state == ST_SETTLE);
   assign IOD_EARLY = r_early;
   assign IOD_LATE  = r_late;
   assign IOD_OOR   = r_oor;

endmodule

// File: tb/tb_icb_dem_tap_responder.sv
// Bench for icb_dem_tap_responder: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a timeline-based behavioural model.
module tb_icb_dem_tap_responder;

   localparam int SETTLE_CNT = 4;
   localparam int EYE_LO     = 64;
   localparam int EYE_HI     = 160;
   localparam int TAP_MAX    = 255;

   logic       SCLK = 1'b0;
   logic       RESET = 1'b1;
   logic       ld = 1'b0, mv = 1'b0, dr = 1'b0, cl = 1'b0;
   logic [7:0] td = 8'd0;
   logic       IOD_EARLY, IOD_LATE, IOD_OOR, BUSY;
   logic [7:0] TAP_VALUE;

   int n_checks = 0;
   int n_fail   = 0;

   icb_dem_tap_responder dut (
      .SCLK                  (SCLK),
      .RESET                 (RESET),
      .ICB_CLK_ALGN_LOAD     (ld),
      .ICB_CLK_ALGN_TAPDLY   (td),
      .ICB_CLK_ALGN_MOV      (mv),
      .ICB_CLK_ALGN_DIR      (dr),
      .ICB_CLK_ALGN_CLR_FLGS (cl),
      .IOD_EARLY             (IOD_EARLY),
      .IOD_LATE              (IOD_LATE),
      .IOD_OOR               (IOD_OOR),
      .TAP_VALUE             (TAP_VALUE),
      .BUSY                  (BUSY)
   );

   always #5 SCLK = ~SCLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: m_age counts cycles since the last accepted LOAD/MOV (0 = no operation in flight).
   // Ages 1..SETTLE_CNT are the busy window, age SETTLE_CNT+1 is the evaluation cycle.
   int          m_tap = 0;
   int          m_age = 0;
   bit          m_e = 0, m_l = 0, m_o = 0;
   bit          m_valid = 0;
   logic [15:0] m_lfsr = 16'hACE1;

   always @(posedge SCLK) begin
      bit se, sl, so, in_eval, idle;
      int ntap, nage;
      if (RESET) begin
         m_tap = 0; m_age = 0; m_e = 0; m_l = 0; m_o = 0;
         m_lfsr = 16'hACE1; m_valid = 1;
      end else begin
         in_eval = (m_age == SETTLE_CNT + 1);
         idle    = (m_age == 0) || in_eval ? (m_age == 0) : 1'b0;
         se = in_eval && (m_tap < EYE_LO);
         sl = in_eval && (m_tap > EYE_HI);
         so = 0;
`ifdef ICB_DEM_JITTER_EN
         if (se && m_tap >= EYE_LO - 3 && !m_lfsr[0]) se = 0;
         if (sl && m_tap <= EYE_HI + 3 && !m_lfsr[0]) sl = 0;
         m_lfsr = {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
`endif
         ntap = m_tap;
         nage = (m_age >= 1 && m_age <= SETTLE_CNT) ? m_age + 1 : 0;
         if (ld) begin
            ntap = int'(td);
            nage = 1;
         end else if (idle && mv) begin
            nage = 1;
            if (dr) begin
               if (m_tap == TAP_MAX) so = 1; else ntap = m_tap + 1;
            end else begin
               if (m_tap == 0) so = 1; else ntap = m_tap - 1;
            end
         end
         m_e = se || (m_e && !cl);
         m_l = sl || (m_l && !cl);
         m_o = so || (m_o && !cl);
         m_tap = ntap;
         m_age = nage;
      end
   end

   always @(negedge SCLK) begin
      if (m_valid) begin
         check("model_tap",   TAP_VALUE, m_tap);
         check("model_busy",  BUSY,      (m_age >= 1 && m_age <= SETTLE_CNT));
         check("model_early", IOD_EARLY, m_e);
         check("model_late",  IOD_LATE,  m_l);
         check("model_oor",   IOD_OOR,   m_o);
      end
   end

   // Drive one cycle of inputs from a negedge, return at the following negedge.
   task automatic cyc(input logic i_ld, input logic [7:0] i_td, input logic i_mv,
                      input logic i_dr, input logic i_cl, input logic i_rs);
      ld = i_ld; td = i_td; mv = i_mv; dr = i_dr; cl = i_cl; RESET = i_rs;
      @(negedge SCLK);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 8'd0, 0, 0, 0, 0);
   endtask

   task automatic pin(input string name, input logic [31:0] dut_v, input int model_v, input int lit);
      check(name, dut_v, lit);
      check({name, "_model"}, model_v, lit);
   endtask

   initial begin
      int   changes;
      logic [7:0] prev;

      @(negedge SCLK);
      cyc(0, 8'd0, 0, 0, 0, 1);
      pin("rst_tap", TAP_VALUE, m_tap, 0);
      check("rst_busy", BUSY, 0);
      pin("rst_early", IOD_EARLY, m_e, 0);
      pin("rst_late", IOD_LATE, m_l, 0);
      pin("rst_oor", IOD_OOR, m_o, 0);

      // First LOAD right after reset release; busy window then early flag.
      cyc(1, 8'd32, 0, 0, 0, 0);
      pin("load32_tap", TAP_VALUE, m_tap, 32);
      for (int i = 0; i < SETTLE_CNT; i++) begin
         check("load32_busy", BUSY, 1);
         idle(1);
      end
      check("load32_eval_busy", BUSY, 0);
      check("load32_eval_early", IOD_EARLY, 0);
      idle(1);
      pin("load32_early", IOD_EARLY, m_e, 1);
      check("load32_late", IOD_LATE, 0);
      check("load32_oor", IOD_OOR, 0);

      cyc(0, 8'd0, 0, 0, 1, 0);
      check("clr_early", IOD_EARLY, 0);
      cyc(1, 8'd100, 0, 0, 0, 0); idle(5);
      check("eye100_early", IOD_EARLY, 0);
      check("eye100_late", IOD_LATE, 0);
      cyc(0, 8'd0, 0, 0, 1, 0);
      cyc(1, 8'd200, 0, 0, 0, 0); idle(5);
      pin("late200_late", IOD_LATE, m_l, 1);
      check("late200_early", IOD_EARLY, 0);

      // Saturation at both ends.
      cyc(0, 8'd0, 0, 0, 1, 0);
      cyc(1, 8'd255, 0, 0, 0, 0); idle(5);
      cyc(0, 8'd0, 1, 1, 0, 0);
      pin("sat_hi_tap", TAP_VALUE, m_tap, 255);
      pin("sat_hi_oor", IOD_OOR, m_o, 1);
      check("sat_hi_busy", BUSY, 1);
      idle(5);
      cyc(1, 8'd0, 0, 0, 0, 0); idle(5);
      cyc(0, 8'd0, 1, 0, 0, 0);
      pin("sat_lo_tap", TAP_VALUE, m_tap, 0);
      check("sat_lo_oor", IOD_OOR, 1);
      idle(5);

      // LOAD+MOV together, then MOV held: one tap update per 6-cycle window.
      cyc(0, 8'd0, 0, 0, 1, 0);
      prev = TAP_VALUE;
      changes = 0;
      for (int i = 0; i < 20; i++) begin
         cyc(i == 0, 8'd100, 1, 1, 0, 0);
         if (i == 0) check("loadmov_tap", TAP_VALUE, 100);
         if (TAP_VALUE != prev) changes++;
         prev = TAP_VALUE;
      end
      cyc(0, 8'd0, 0, 0, 0, 0);
      pin("hold_mov_tap", TAP_VALUE, m_tap, 103);
      check("hold_mov_updates", changes, 4);
      idle(6);

      // CLR_FLGS during the EVAL cycle of an out-of-eye tap loses to the set.
      cyc(0, 8'd0, 0, 0, 1, 0);
      cyc(1, 8'd10, 0, 0, 0, 0); idle(SETTLE_CNT);
      check("clr_eval_busy", BUSY, 0);
      cyc(0, 8'd0, 0, 0, 1, 0);
      pin("clr_eval_early", IOD_EARLY, m_e, 1);

      // Reset in the second settle cycle aborts the evaluation.
      cyc(0, 8'd0, 0, 0, 1, 0);
      cyc(1, 8'd10, 0, 0, 0, 0);
      idle(1);
      cyc(0, 8'd0, 0, 0, 0, 1);
      check("abort_tap", TAP_VALUE, 0);
      check("abort_busy", BUSY, 0);
      check("abort_flags", {IOD_EARLY, IOD_LATE, IOD_OOR}, 0);
      for (int i = 0; i < 8; i++) begin
         idle(1);
         check("abort_no_early", IOD_EARLY, 0);
      end

`ifdef ICB_DEM_JITTER_EN
      for (int i = 0; i < 12; i++) begin
         cyc(0, 8'd0, 0, 0, 1, 0);
         cyc(1, 8'd63, 0, 0, 0, 0);
         idle(5 + (i % 3));
      end
`endif

      // Randomized traffic, biased toward the eye edges and the range ends.
      for (int i = 0; i < 3000; i++) begin
         logic [7:0] t;
         case ($urandom_range(0, 3))
            0:       t = 8'($urandom_range(0, 255));
            1:       t = 8'($urandom_range(EYE_LO - 4, EYE_LO + 1));
            2:       t = 8'($urandom_range(EYE_HI - 1, EYE_HI + 4));
            default: t = ($urandom_range(0, 1) != 0) ? 8'd255 : 8'd0;
         endcase
         cyc($urandom_range(0, 9) == 0, t, $urandom_range(0, 1) != 0,
             $urandom_range(0, 1) != 0, $urandom_range(0, 15) == 0,
             $urandom_range(0, 199) == 0);
      end
      idle(2);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
